mux_8_to_1: RTL and testbench
=============================

# mux_8_to_1

Eight-input, 16-bit (parameterizable) word multiplexer for the CPU datapath, selecting one of eight operand sources by a 3-bit select. It provides a zero-latency combinational output for in-cycle use, plus a registered, enable-gated copy for pipelined consumers. It sits between the register/immediate/ALU sources and downstream datapath stages.

## Interface
- WIDTH, default 16: data width of every input and output word.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- en  input  1  register-stage load enable.
- sel  input  3  source select, 0..7.
- in0 … in7  input  WIDTH each  candidate data words.
- out  output  WIDTH  combinational selected word.
- out_q  output  WIDTH  registered selected word.
- out_valid  output  1  high when out_q holds a word loaded since reset.

## Operation
- out = in[sel], fully combinational: sel=0→in0, 1→in1, …, 7→in7.
  - No latch.
  - All 8 select codes are decoded; no default/X case is reachable.
- out changes within the same delta cycle as any change on sel or the selected input.
- Changes on non-selected inputs have no effect on out.
- Registered stage, at each rising clk:
  - rst=1: out_q←0 and out_valid←0. rst has priority over en.
  - rst=0, en=1: out_q←out as it stands at that edge; out_valid←1.
  - rst=0, en=0: out_q and out_valid hold.
- out is not affected by rst or en.
- No arithmetic is performed. Widths are pass-through; no sign or zero extension.
- If sel contains X/Z, out is X in simulation. No synthesis requirement applies to that case.

## Timing
- out: 0-cycle latency, combinational.
- out_q: 1-cycle latency. The value at edge N appears after edge N.
- Reset values:
  - out_q = 0, out_valid = 0.
  - out is combinational and has no reset value.
- Reset asserted mid-stream: the next edge clears out_q and out_valid regardless of en. The first en=1 edge after reset deasserts sets out_valid.
- Back-to-back en=1 cycles: every edge loads, giving full throughput.
- sel and inputs may change every cycle. out_q captures only the values present at the sampling edge.

## Structure
- Shared package (datapath pkg):
  - WORD_W = 16 default.
  - Typedef for a word.
  - 3-bit select typedef.
  - Named select constants SEL_IN0..SEL_IN7 = 0..7.
- One natural sub-module, mux_2to1 (WIDTH-parameterized, combinational). The 8:1 is built as a 3-level tree:
  - Level 1 uses sel[0].
  - Level 2 uses sel[1].
  - Level 3 uses sel[2].
- A flat case statement is equally acceptable if the sub-module is not wanted.
- Output register and valid flag live in the top module.

## Test plan
- Sweep select, combinational check:
  - Inputs in0..in7 = 5, 6, 12, 16, 9, 10, 25, 33.
  - Step sel 0..7, 10 ns apart.
  - Required out = 5, 6, 12, 16, 9, 10, 25, 33 respectively, valid with no clock edge required.
- Non-selected isolation:
  - Set sel=3 and in3=16.
  - Toggle in0, in1, in2, in4, in5, in6, in7 to 0xFFFF.
  - Required out stays 16. Then change in3 to 0xA5A5 and require out=0xA5A5 immediately.
- Reset:
  - Hold rst=1, en=1 for 2 edges with sel=7, in7=33.
  - Required out_q=0, out_valid=0, while out=33.
  - Release rst; after the next edge require out_q=33, out_valid=1.
- Enable hold:
  - Load out_q=25 with sel=6 and en=1.
  - Drop en, set sel=1 (in1=6), clock 3 edges.
  - Required out_q=25 throughout while out=6. Raise en; after 1 edge require out_q=6.
- Pipeline throughput:
  - With en=1, sel=0,1,2,3 on consecutive edges and inputs as in the first scenario.
  - Required out_q = 5, 6, 12, 16 on the following consecutive cycles.
- Extremes and mid-stream reset:
  - Set in5=0xFFFF, in2=0x0000.
  - Alternate sel 5/2 each cycle with en=1; assert rst for one edge mid-sequence.
  - Required out_q = 0xFFFF/0x0000 alternating, forced to 0 with out_valid=0 for the reset cycle, then resuming on the next edge.

Source files
------------

// File: rtl/mux_8_to_1_pkg.sv
// Shared datapath definitions for the operand-select multiplexer.
package mux_8_to_1_pkg;

   localparam int WORD_W = 16;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [2:0]        sel_t;

   localparam sel_t SEL_IN0 = 3'd0;
   localparam sel_t SEL_IN1 = 3'd1;
   localparam sel_t SEL_IN2 = 3'd2;
   localparam sel_t SEL_IN3 = 3'd3;
   localparam sel_t SEL_IN4 = 3'd4;
   localparam sel_t SEL_IN5 = 3'd5;
   localparam sel_t SEL_IN6 = 3'd6;
   localparam sel_t SEL_IN7 = 3'd7;

endpackage

// File: rtl/mux_8_to_1_mux_2to1.sv
// Width-parameterized 2:1 word select, leaf cell of the 8:1 tree.
module mux_2to1 #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s,
   output logic [WIDTH-1:0] y
);

   // s=0 passes a, s=1 passes b; an unknown s propagates X in simulation
   always_comb begin
      y = s ? b : a;
   end

endmodule

// File: rtl/mux_8_to_1.sv
// 8:1 operand mux: combinational out plus an enable-gated registered copy.
module mux_8_to_1
   import mux_8_to_1_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       sel,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   input  logic [WIDTH-1:0] in4,
   input  logic [WIDTH-1:0] in5,
   input  logic [WIDTH-1:0] in6,
   input  logic [WIDTH-1:0] in7,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
   output logic             out_valid
);

   logic [7:0][WIDTH-1:0] src;
   logic [3:0][WIDTH-1:0] lvl1;
   logic [1:0][WIDTH-1:0] lvl2;

   assign src = {in7, in6, in5, in4, in3, in2, in1, in0};

   // Tree: sel[0] picks within pairs, sel[1] within quads, sel[2] final
   for (genvar g = 0; g < 4; g++) begin : g_lvl1
      mux_2to1 #(.WIDTH(WIDTH)) u_mux (
         .a (src[2*g]),
         .b (src[2*g+1]),
         .s (sel[0]),
         .y (lvl1[g])
      );
   end

   for (genvar g = 0; g < 2; g++) begin : g_lvl2
      mux_2to1 #(.WIDTH(WIDTH)) u_mux (
         .a (lvl1[2*g]),
         .b (lvl1[2*g+1]),
         .s (sel[1]),
         .y (lvl2[g])
      );
   end

   mux_2to1 #(.WIDTH(WIDTH)) u_lvl3 (
      .a (lvl2[0]),
      .b (lvl2[1]),
      .s (sel[2]),
      .y (out)
   );

   // Output stage: reset wins over enable; valid marks a load since reset
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q     <= '0;
         out_valid <= 1'b0;
      end else if (en) begin
         out_q     <= out;
         out_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mux_8_to_1.sv
// Directed plus randomized bench for mux_8_to_1 with an array-indexed reference.
module tb_mux_8_to_1;

   logic        clk = 1'b0;
   logic        rst, en;
   logic [2:0]  sel;
   logic [15:0] ins [8];
   logic [15:0] out, out_q;
   logic        out_valid;

   logic [15:0] exp_q;
   logic        exp_v;
   int          nvec = 0;
   int          nerr = 0;

   localparam logic [15:0] TBL [8] = '{16'd5, 16'd6, 16'd12, 16'd16,
                                       16'd9, 16'd10, 16'd25, 16'd33};

   mux_8_to_1 #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .sel       (sel),
      .in0       (ins[0]),
      .in1       (ins[1]),
      .in2       (ins[2]),
      .in3       (ins[3]),
      .in4       (ins[4]),
      .in5       (ins[5]),
      .in6       (ins[6]),
      .in7       (ins[7]),
      .out       (out),
      .out_q     (out_q),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   // Reference register: the selected word is simply ins[sel] at the edge
   always @(posedge clk) begin
      if (rst) begin
         exp_q <= 16'd0;
         exp_v <= 1'b0;
      end else if (en) begin
         exp_q <= ins[sel];
         exp_v <= 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      nvec++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_table();
      for (int k = 0; k < 8; k++) ins[k] = TBL[k];
   endtask

   initial begin
      logic [15:0] e;
      rst = 1'b1; en = 1'b1; sel = 3'd7;
      load_table();

      // reset held for two edges with en high
      tick(); tick();
      chk("rst_out_q", out_q, 16'd0);
      chk("rst_valid", {15'd0, out_valid}, 16'd0);
      chk("rst_out",   out, 16'd33);
      rst = 1'b0;
      tick();
      chk("post_rst_q",     out_q, 16'd33);
      chk("post_rst_valid", {15'd0, out_valid}, 16'd1);

      // combinational select sweep, register stage idle
      en = 1'b0;
      for (int s = 0; s < 8; s++) begin
         sel = 3'(s);
         #1;
         chk($sformatf("sweep_sel%0d", s), out, TBL[s]);
         #9;
      end
      chk("sweep_hold_q", out_q, 16'd33);

      // non-selected inputs must not disturb out
      sel = 3'd3;
      ins[3] = 16'd16;
      for (int k = 0; k < 8; k++) if (k != 3) ins[k] = 16'hFFFF;
      #1;
      chk("isolate", out, 16'd16);
      ins[3] = 16'hA5A5;
      #1;
      chk("isolate_sel_chg", out, 16'hA5A5);

      // enable hold
      load_table();
      sel = 3'd6; en = 1'b1;
      tick();
      chk("en_load", out_q, 16'd25);
      en = 1'b0; sel = 3'd1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("en_hold_q%0d", i), out_q, 16'd25);
         chk($sformatf("en_hold_out%0d", i), out, 16'd6);
      end
      en = 1'b1;
      tick();
      chk("en_reload", out_q, 16'd6);

      // back-to-back loads
      for (int s = 0; s < 4; s++) begin
         sel = 3'(s);
         tick();
         chk($sformatf("thru%0d", s), out_q, TBL[s]);
      end

      // extremes with a one-edge reset in the middle
      ins[5] = 16'hFFFF; ins[2] = 16'h0000;
      for (int i = 0; i < 8; i++) begin
         sel = (i % 2 == 0) ? 3'd5 : 3'd2;
         rst = (i == 4);
         tick();
         e = (i == 4) ? 16'h0000 : ((i % 2 == 0) ? 16'hFFFF : 16'h0000);
         chk($sformatf("ext_q%0d", i), out_q, e);
         chk($sformatf("ext_v%0d", i), {15'd0, out_valid}, (i == 4) ? 16'd0 : 16'd1);
      end
      rst = 1'b0;

      // randomized traffic against the reference
      for (int i = 0; i < 300; i++) begin
         for (int k = 0; k < 8; k++) ins[k] = 16'($urandom);
         sel = 3'($urandom_range(0, 7));
         en  = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 15) == 0);
         #1;
         chk("rnd_out", out, ins[sel]);
         tick();
         chk("rnd_q", out_q, exp_q);
         chk("rnd_v", {15'd0, out_valid}, {15'd0, exp_v});
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
